// File: rtl/stream_mem_reader_pkg.sv
// Shared definitions for the stream memory reader: default widths, memory/FIFO
// latency defaults, FSM state encoding and the skid-sizing rule.
package stream_mem_reader_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 32;
  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_LEN_WIDTH   = 16;
  localparam int unsigned DEF_MEM_LATENCY = 2;
  localparam int unsigned DEF_FIFO_SKID   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Words issued but not yet pushed must always fit in the downstream skid region.
  function automatic bit skid_ok(input int unsigned mem_latency, input int unsigned fifo_skid);
    return (mem_latency + 1) < fifo_skid;
  endfunction

endpackage

// File: rtl/stream_mem_reader_if.sv
// Memory read port plus FIFO write port of the stream reader, grouped as one bus.
interface stream_mem_reader_if
  import stream_mem_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic [ADDR_WIDTH-1:0] memAddrOut;
  logic                  memRdEnOut;
  logic [DATA_WIDTH-1:0] memRdDataIn;
  logic [DATA_WIDTH-1:0] wrDataOut;
  logic                  wrValidOut;
  logic                  wrReadyIn;

  modport master (
    output memAddrOut,
    output memRdEnOut,
    input  memRdDataIn,
    output wrDataOut,
    output wrValidOut,
    input  wrReadyIn
  );

  modport slave (
    input  memAddrOut,
    input  memRdEnOut,
    output memRdDataIn,
    input  wrDataOut,
    input  wrValidOut,
    output wrReadyIn
  );

endinterface

// File: rtl/stream_mem_reader_latency_pipe.sv
// Valid shift register matching a fixed-latency memory; o_tail is high in the
// cycle the memory presents data for a strobe issued DEPTH cycles earlier.
module stream_mem_reader_latency_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_valid,
  output logic o_tail
);

  logic [DEPTH-1:0] r_pipe;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_valid;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_tail = r_pipe[DEPTH-1];

endmodule

// File: rtl/stream_mem_reader.sv
// Read-DMA front end: issues sequential reads to a fixed-latency memory and
// pushes the returned words into a skid-buffered FIFO, pacing issue on wrReadyIn.
module stream_mem_reader
  import stream_mem_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH   = DEF_LEN_WIDTH,
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int unsigned FIFO_SKID   = DEF_FIFO_SKID
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  startIn,
  input  logic [ADDR_WIDTH-1:0] baseAddrIn,
  input  logic [LEN_WIDTH-1:0]  lengthIn,
  output logic                  busyOut,
  output logic                  doneOut,
  stream_mem_reader_if.master   bus
);

  localparam int unsigned INFL_MAX = MEM_LATENCY + 1;
  localparam int unsigned INFL_W   = $clog2(INFL_MAX + 1);

  if (MEM_LATENCY < 1) begin : g_lat_chk
    $error("stream_mem_reader: MEM_LATENCY must be at least 1");
  end

  if (!skid_ok(MEM_LATENCY, FIFO_SKID)) begin : g_skid_chk
    $error("stream_mem_reader: MEM_LATENCY+1 must be below FIFO_SKID");
  end

  state_e                r_state;
  state_e                w_next_state;
  logic                  w_issue;
  logic                  w_tail;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [INFL_W-1:0]     r_inflight;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_wr_valid;
  logic [DATA_WIDTH-1:0] r_wr_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and issue strobe; issue follows wrReadyIn in the same cycle.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (startIn) begin
          w_next_state = (lengthIn == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_issue = bus.wrReadyIn;
        if (w_issue && (r_remaining == LEN_WIDTH'(1))) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_inflight == '0) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  stream_mem_reader_latency_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_latency_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (1'b0),
    .i_valid (w_issue),
    .o_tail  (w_tail)
  );

  // Address/length tracking and in-flight accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= '0;
    end else begin
      if ((r_state == ST_IDLE) && startIn) begin
        r_addr      <= baseAddrIn;
        r_remaining <= lengthIn;
      end else if (w_issue) begin
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - LEN_WIDTH'(1);
      end
      // A word leaves the in-flight set when its return is captured for push.
      case ({w_issue, w_tail})
        2'b10:   r_inflight <= r_inflight + INFL_W'(1);
        2'b01:   r_inflight <= r_inflight - INFL_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Return capture and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_valid <= 1'b0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wr_valid <= w_tail;
      if (w_tail) begin
        r_wr_data <= bus.memRdDataIn;
      end
      r_busy <= (w_next_state == ST_ISSUE) || (w_next_state == ST_DRAIN);
      r_done <= (w_next_state == ST_DONE);
    end
  end

  assign bus.memAddrOut = r_addr;
  assign bus.memRdEnOut = w_issue;
  assign bus.wrDataOut  = r_wr_data;
  assign bus.wrValidOut = r_wr_valid;
  assign busyOut        = r_busy;
  assign doneOut        = r_done;

endmodule

// File: tb/tb_stream_mem_reader.sv
// Directed bench for stream_mem_reader with a 2-cycle memory model returning
// addr ^ 0xA5A50000 and a small FIFO occupancy model for backpressure.
module tb_stream_mem_reader;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startIn = 1'b0;
  logic [31:0] baseAddrIn = '0;
  logic [15:0] lengthIn = '0;
  logic        busyOut;
  logic        doneOut;

  stream_mem_reader_if bus ();

  stream_mem_reader dut (
    .clk        (clk),
    .rst        (rst),
    .startIn    (startIn),
    .baseAddrIn (baseAddrIn),
    .lengthIn   (lengthIn),
    .busyOut    (busyOut),
    .doneOut    (doneOut),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Memory: data for a strobe in cycle t is presented in cycle t+2.
  logic [31:0] m0, m1;
  always @(posedge clk) begin
    m0 <= bus.memAddrOut;
    m1 <= m0;
  end
  assign bus.memRdDataIn = m1 ^ KEY;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;
  bit tog_ready = 1'b0;

  logic [31:0] st_addr[$];
  int          st_cyc[$];
  logic        st_rdy[$];
  logic        st_busy[$];
  logic [31:0] pu_data[$];
  int          pu_cyc[$];
  int          dn_cyc[$];
  logic        dn_busy[$];

  // Event log sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.memRdEnOut === 1'b1) begin
        st_addr.push_back(bus.memAddrOut);
        st_cyc.push_back(cyc);
        st_rdy.push_back(bus.wrReadyIn);
        st_busy.push_back(busyOut);
      end
      if (bus.wrValidOut === 1'b1) begin
        pu_data.push_back(bus.wrDataOut);
        pu_cyc.push_back(cyc);
      end
      if (doneOut === 1'b1) begin
        dn_cyc.push_back(cyc);
        dn_busy.push_back(busyOut);
      end
    end
  end

  task automatic clear_logs();
    st_addr.delete(); st_cyc.delete(); st_rdy.delete(); st_busy.delete();
    pu_data.delete(); pu_cyc.delete(); dn_cyc.delete(); dn_busy.delete();
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] len, output int s);
    @(posedge clk); #1;
    startIn = 1'b1; baseAddrIn = base; lengthIn = len; s = cyc;
    @(posedge clk); #1;
    startIn = 1'b0;
  endtask

  task automatic run_until_done(input int n_done, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (tog_ready) bus.wrReadyIn = ~bus.wrReadyIn;
      if (dn_cyc.size() >= n_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.wrReadyIn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busyOut, doneOut, bus.memRdEnOut, bus.wrValidOut} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {busyOut, doneOut, bus.memRdEnOut, bus.wrValidOut});
    end
    tests_run++;
    if (bus.memAddrOut !== 32'h0 || bus.wrDataOut !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_buses: got addr %h data %h expected 0 0", bus.memAddrOut, bus.wrDataOut);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busyOut, bus.memRdEnOut, bus.wrValidOut} !== 3'b000) begin
      tests_failed++;
      $display("FAIL idle_quiet: got %b expected 000", {busyOut, bus.memRdEnOut, bus.wrValidOut});
    end
  endtask

  task automatic test_basic();
    int s; bit ok; logic [31:0] e;
    clear_logs(); bus.wrReadyIn = 1'b1;
    do_start(32'h100, 16'd4, s);
    run_until_done(1, 50, ok);
    repeat (3) @(posedge clk);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL basic_done_timeout: got none expected done"); end
    tests_run++;
    if (st_addr.size() != 4 || pu_data.size() != 4) begin
      tests_failed++;
      $display("FAIL basic_counts: got %0d strobes %0d pushes expected 4 4", st_addr.size(), pu_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      e = 32'h100 + 32'(i);
      tests_run++;
      if (i >= st_addr.size() || st_addr[i] !== e || st_cyc[i] != s + 1 + i) begin
        tests_failed++;
        $display("FAIL basic_strobe[%0d]: got %h @%0d expected %h @%0d", i,
                 (i < st_addr.size()) ? st_addr[i] : 32'hx, (i < st_cyc.size()) ? st_cyc[i] : -1, e, s + 1 + i);
      end
      tests_run++;
      if (i >= pu_data.size() || pu_data[i] !== (e ^ KEY) || pu_cyc[i] != s + 4 + i) begin
        tests_failed++;
        $display("FAIL basic_push[%0d]: got %h @%0d expected %h @%0d", i,
                 (i < pu_data.size()) ? pu_data[i] : 32'hx, (i < pu_cyc.size()) ? pu_cyc[i] : -1, e ^ KEY, s + 4 + i);
      end
    end
    tests_run++;
    if (dn_cyc.size() != 1 || dn_cyc[0] != s + 8 || dn_busy[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done: got %0d pulses first @%0d expected 1 @%0d busy 0", dn_cyc.size(),
               (dn_cyc.size() > 0) ? dn_cyc[0] : -1, s + 8);
    end
    tests_run++;
    if (st_busy.size() == 0 || st_busy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_busy: got %b expected 1 at first strobe", (st_busy.size() > 0) ? st_busy[0] : 1'bx);
    end
  endtask

  task automatic test_len0();
    int s; bit ok;
    clear_logs(); bus.wrReadyIn = 1'b1;
    do_start(32'h700, 16'd0, s);
    run_until_done(1, 20, ok);
    repeat (3) @(posedge clk);
    tests_run++;
    if (!ok || st_addr.size() != 0 || pu_data.size() != 0) begin
      tests_failed++;
      $display("FAIL len0_activity: got done %0b strobes %0d pushes %0d expected 1 0 0", ok, st_addr.size(), pu_data.size());
    end
    tests_run++;
    if (dn_cyc.size() != 1 || dn_cyc[0] != s + 1) begin
      tests_failed++;
      $display("FAIL len0_done: got %0d pulses @%0d expected 1 @%0d", dn_cyc.size(), (dn_cyc.size() > 0) ? dn_cyc[0] : -1, s + 1);
    end
  endtask

  task automatic test_toggle_ready();
    int s, errs; bit ok;
    clear_logs(); bus.wrReadyIn = 1'b0;
    do_start(32'h800, 16'd10, s);
    tog_ready = 1'b1;
    run_until_done(1, 100, ok);
    tog_ready = 1'b0; bus.wrReadyIn = 1'b1;
    tests_run++;
    if (!ok || st_addr.size() != 10 || pu_data.size() != 10) begin
      tests_failed++;
      $display("FAIL toggle_counts: got done %0b strobes %0d pushes %0d expected 1 10 10", ok, st_addr.size(), pu_data.size());
    end
    errs = 0;
    for (int i = 0; i < st_addr.size(); i++)
      if (st_rdy[i] !== 1'b1 || st_addr[i] !== 32'h800 + 32'(i) || st_cyc[i] != s + 2 + 2 * i) errs++;
    tests_run++;
    if (errs != 0) begin tests_failed++; $display("FAIL toggle_strobes: got %0d bad strobes expected 0", errs); end
    errs = 0;
    for (int i = 0; i < pu_data.size(); i++)
      if (pu_data[i] !== ((32'h800 + 32'(i)) ^ KEY) || pu_cyc[i] != s + 5 + 2 * i) errs++;
    tests_run++;
    if (errs != 0) begin tests_failed++; $display("FAIL toggle_pushes: got %0d bad pushes expected 0", errs); end
    tests_run++;
    if (dn_cyc.size() != 1 || dn_cyc[0] != s + 24) begin
      tests_failed++;
      $display("FAIL toggle_done: got @%0d expected @%0d", (dn_cyc.size() > 0) ? dn_cyc[0] : -1, s + 24);
    end
  endtask

  task automatic test_reset_mid();
    int s, vcount; bit ok;
    clear_logs(); bus.wrReadyIn = 1'b1;
    do_start(32'h200, 16'd8, s);
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busyOut, doneOut, bus.memRdEnOut, bus.wrValidOut} !== 4'b0000 || bus.memAddrOut !== 32'h0 || bus.wrDataOut !== 32'h0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got flags %b addr %h data %h expected 0", {busyOut, doneOut, bus.memRdEnOut, bus.wrValidOut},
               bus.memAddrOut, bus.wrDataOut);
    end
    vcount = 0;
    repeat (6) begin @(negedge clk); if (bus.wrValidOut !== 1'b0) vcount++; end
    tests_run++;
    if (vcount != 0 || st_addr.size() != 3 || dn_cyc.size() != 0) begin
      tests_failed++;
      $display("FAIL rstmid_drop: got %0d late pushes %0d strobes %0d dones expected 0 3 0", vcount, st_addr.size(), dn_cyc.size());
    end
    clear_logs();
    do_start(32'h300, 16'd2, s);
    run_until_done(1, 30, ok);
    tests_run++;
    if (!ok || pu_data.size() != 2 || pu_data[0] !== (32'h300 ^ KEY) || pu_data[1] !== (32'h301 ^ KEY)) begin
      tests_failed++;
      $display("FAIL rstmid_restart: got done %0b pushes %0d expected 1 2 with data %h %h", ok, pu_data.size(), 32'h300 ^ KEY, 32'h301 ^ KEY);
    end
  endtask

  task automatic test_ignore_start();
    int s, errs; bit ok;
    clear_logs(); bus.wrReadyIn = 1'b1;
    do_start(32'h400, 16'd6, s);
    @(posedge clk); #1; startIn = 1'b1; baseAddrIn = 32'h900; lengthIn = 16'd2;
    @(posedge clk); #1; startIn = 1'b0;
    run_until_done(1, 40, ok);
    repeat (4) @(posedge clk);
    errs = 0;
    for (int i = 0; i < st_addr.size(); i++) if (st_addr[i] !== 32'h400 + 32'(i)) errs++;
    for (int i = 0; i < pu_data.size(); i++) if (pu_data[i] !== ((32'h400 + 32'(i)) ^ KEY)) errs++;
    tests_run++;
    if (!ok || errs != 0 || st_addr.size() != 6 || pu_data.size() != 6) begin
      tests_failed++;
      $display("FAIL ignore_start: got done %0b errs %0d strobes %0d pushes %0d expected 1 0 6 6", ok, errs, st_addr.size(), pu_data.size());
    end
    tests_run++;
    if (dn_cyc.size() != 1 || dn_cyc[0] != s + 10) begin
      tests_failed++;
      $display("FAIL ignore_done: got %0d pulses @%0d expected 1 @%0d", dn_cyc.size(), (dn_cyc.size() > 0) ? dn_cyc[0] : -1, s + 10);
    end
  endtask

  task automatic test_wrap();
    int s; bit ok;
    logic [31:0] ea[4];
    logic [31:0] ed[4];
    ea = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    ed = '{32'h5A5A_FFFE, 32'h5A5A_FFFF, 32'hA5A5_0000, 32'hA5A5_0001};
    clear_logs(); bus.wrReadyIn = 1'b1;
    do_start(32'hFFFF_FFFE, 16'd4, s);
    run_until_done(1, 30, ok);
    tests_run++;
    if (!ok || st_addr.size() != 4 || pu_data.size() != 4) begin
      tests_failed++;
      $display("FAIL wrap_counts: got done %0b strobes %0d pushes %0d expected 1 4 4", ok, st_addr.size(), pu_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= st_addr.size() || i >= pu_data.size() || st_addr[i] !== ea[i] || pu_data[i] !== ed[i]) begin
        tests_failed++;
        $display("FAIL wrap[%0d]: got addr %h data %h expected %h %h", i,
                 (i < st_addr.size()) ? st_addr[i] : 32'hx, (i < pu_data.size()) ? pu_data[i] : 32'hx, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int s; bit ok;
    clear_logs(); bus.wrReadyIn = 1'b1;
    do_start(32'h500, 16'd3, s);
    repeat (6) begin @(posedge clk); #1; end
    startIn = 1'b1; baseAddrIn = 32'h600; lengthIn = 16'd2;
    @(posedge clk); #1;
    @(posedge clk); #1; startIn = 1'b0;
    run_until_done(2, 30, ok);
    tests_run++;
    if (!ok || st_addr.size() != 5 || dn_cyc.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_counts: got done %0b strobes %0d dones %0d expected 1 5 2", ok, st_addr.size(), dn_cyc.size());
    end
    tests_run++;
    if (dn_cyc.size() < 2 || dn_cyc[0] != s + 7 || dn_cyc[1] != s + 14) begin
      tests_failed++;
      $display("FAIL b2b_done: got @%0d @%0d expected @%0d @%0d", (dn_cyc.size() > 0) ? dn_cyc[0] : -1,
               (dn_cyc.size() > 1) ? dn_cyc[1] : -1, s + 7, s + 14);
    end
    tests_run++;
    if (st_addr.size() < 5 || st_addr[3] !== 32'h600 || st_cyc[3] != s + 9 || st_addr[4] !== 32'h601) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h @%0d expected 00000600 @%0d", (st_addr.size() > 3) ? st_addr[3] : 32'hx,
               (st_cyc.size() > 3) ? st_cyc[3] : -1, s + 9);
    end
  endtask

  task automatic test_fifo_backpressure();
    int s, popped, occ, maxocc, errs; bit ok;
    clear_logs(); bus.wrReadyIn = 1'b1; popped = 0; maxocc = 0;
    do_start(32'h1000, 16'd64, s);
    repeat (60) begin
      @(posedge clk); #1;
      occ = pu_data.size() - popped;
      if (occ > maxocc) maxocc = occ;
      bus.wrReadyIn = (occ <= 32);
    end
    tests_run++;
    if (st_addr.size() != 36 || pu_data.size() != 36 || maxocc != 36) begin
      tests_failed++;
      $display("FAIL fifo_stall: got strobes %0d pushes %0d peak %0d expected 36 36 36", st_addr.size(), pu_data.size(), maxocc);
    end
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      if (pu_data.size() > popped) popped++;
      occ = pu_data.size() - popped;
      if (occ > maxocc) maxocc = occ;
      bus.wrReadyIn = (occ <= 32);
      if (dn_cyc.size() >= 1) ok = 1'b1;
    end
    bus.wrReadyIn = 1'b1;
    errs = 0;
    for (int i = 0; i < pu_data.size(); i++) if (pu_data[i] !== ((32'h1000 + 32'(i)) ^ KEY)) errs++;
    for (int i = 0; i < st_addr.size(); i++) if (st_addr[i] !== 32'h1000 + 32'(i)) errs++;
    tests_run++;
    if (!ok || errs != 0 || pu_data.size() != 64 || st_addr.size() != 64 || maxocc > 64) begin
      tests_failed++;
      $display("FAIL fifo_drain: got done %0b errs %0d pushes %0d strobes %0d peak %0d expected 1 0 64 64 <=64",
               ok, errs, pu_data.size(), st_addr.size(), maxocc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wrReadyIn = 1'b1;
    test_reset();
    test_basic();
    test_len0();
    test_toggle_ready();
    test_reset_mid();
    test_ignore_start();
    test_wrap();
    test_back_to_back();
    test_fifo_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
